// File: rtl/seq_alu_acc_if.sv
// Operand/handshake bundle between the switch/key front end and the accumulator ALU.
interface seq_alu_acc_if #(
  parameter int unsigned N = 4
) ();

  logic             Start;
  logic [2:0]       Function;
  logic             UseAcc;
  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic             Busy;
  logic             Done;
  logic [2*N-1:0]   ALUout;

  modport master (
    output Start, Function, UseAcc, A, B,
    input  Busy, Done, ALUout
  );

  modport slave (
    input  Start, Function, UseAcc, A, B,
    output Busy, Done, ALUout
  );

endinterface

// File: rtl/seq_alu_acc.sv
// Registered eight-function ALU with a 2N-bit accumulator and a shift-add multiplier.
// Start is taken only in idle; Done pulses for one cycle when ALUout holds a new result.
module seq_alu_acc #(
  parameter int unsigned N = 4
) (
  input logic          Clock,
  input logic          Reset_b,
  seq_alu_acc_if.slave bus
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    aluout_q, aluout_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    prod_q, prod_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N-1:0]    bop;
  logic [W-1:0]    a_ext;
  logic [W-1:0]    b_ext;
  logic [W-1:0]    prod_add;

  // The accumulator feedback uses the register value as it stands at the accept edge.
  assign bop      = bus.UseAcc ? aluout_q[N-1:0] : bus.B;
  assign a_ext    = {{N{1'b0}}, bus.A};
  assign b_ext    = {{N{1'b0}}, bop};
  assign prod_add = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  // Next-state, operation decode and multiply step.
  always_comb begin
    state_d  = state_q;
    aluout_d = aluout_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          state_d = StDone;
          case (bus.Function)
            3'b000:  aluout_d = a_ext + b_ext;
            3'b001:  aluout_d = a_ext - b_ext;
            3'b010:  aluout_d = {{(W-1){1'b0}}, |{bus.A, bop}};
            3'b011:  aluout_d = {{(W-1){1'b0}}, &{bus.A, bop}};
            3'b100:  aluout_d = {bus.A, bop};
            3'b101: begin
              // ALUout is left alone until the product is complete.
              state_d  = StMul;
              mcand_d  = a_ext;
              mplier_d = bop;
              prod_d   = '0;
              cnt_d    = CW'(N);
            end
            3'b110:  aluout_d = a_ext ^ b_ext;
            default: aluout_d = '0;
          endcase
        end
      end
      StMul: begin
        prod_d   = prod_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = StDone;
          aluout_d = prod_add;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-multiply.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q  <= StIdle;
      aluout_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      aluout_q <= aluout_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.Busy   = (state_q != StIdle);
  assign bus.Done   = (state_q == StDone);
  assign bus.ALUout = aluout_q;

endmodule

// File: tb/tb_seq_alu_acc.sv
// Self-checking bench for seq_alu_acc (N=4) against an arithmetic reference model.
module tb_seq_alu_acc;

  localparam int N    = 4;
  localparam int MASK = (1 << (2 * N)) - 1;

  logic Clock;
  logic Reset_b;
  int   errors;
  int   checks;
  int   acc;

  seq_alu_acc_if #(.N(N)) bus ();

  seq_alu_acc #(.N(N)) dut (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference result of one operation, straight from the function table.
  function automatic int ref_op(input int f, input int a, input int b);
    case (f)
      0:       return (a + b) & MASK;
      1:       return (a - b) & MASK;
      2:       return ((a != 0) || (b != 0)) ? 1 : 0;
      3:       return ((a == 15) && (b == 15)) ? 1 : 0;
      4:       return (a * 16 + b) & MASK;
      5:       return (a * b) & MASK;
      6:       return a ^ b;
      default: return 0;
    endcase
  endfunction

  // Wait for idle, then present one request and accept it on the next rising edge.
  task automatic issue(input int f, input int a, input int b, input bit ua);
    int guard;
    guard = 0;
    @(negedge Clock);
    while (bus.Busy && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    bus.Function = 3'(f);
    bus.A        = 4'(a);
    bus.B        = 4'(b);
    bus.UseAcc   = ua;
    bus.Start    = 1'b1;
    @(posedge Clock);
    #1;
    bus.Start    = 1'b0;
  endtask

  // Cycles from the accept edge until Done is seen; -1 if it never arrives.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!bus.Done && cycles < 20) begin
      @(posedge Clock);
      #1;
      cycles++;
    end
    if (!bus.Done) cycles = -1;
  endtask

  // Model the accumulator update for a request and return the expected value.
  function automatic int model_op(input int f, input int a, input int b, input bit ua);
    int bop;
    bop = ua ? (acc & 15) : b;
    acc = ref_op(f, a, bop);
    return acc;
  endfunction

  task automatic test_reset();
    int cyc;
    int exp;
    exp = model_op(0, 15, 1, 1'b0);
    issue(0, 15, 1, 1'b0);
    wait_done(cyc);
    checks++;
    if (bus.ALUout !== 8'(exp)) begin
      errors++;
      $display("FAIL reset_setup: ALUout=%h expected %h", bus.ALUout, 8'(exp));
    end
    @(negedge Clock);
    #2;
    Reset_b = 1'b0;
    #1;
    acc = 0;
    checks++;
    if (bus.ALUout !== 8'h00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ALUout=%h Busy=%b Done=%b expected 00 0 0",
               bus.ALUout, bus.Busy, bus.Done);
    end
    @(negedge Clock);
    Reset_b = 1'b1;
  endtask

  task automatic test_add();
    int cyc;
    int exp;
    exp = model_op(0, 15, 1, 1'b0);
    issue(0, 15, 1, 1'b0);
    checks++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b1 || bus.ALUout !== 8'h10 || exp != 8'h10) begin
      errors++;
      $display("FAIL add_done: Done=%b Busy=%b ALUout=%h expected 1 1 10",
               bus.Done, bus.Busy, bus.ALUout);
    end
    @(posedge Clock);
    #1;
    checks++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL add_idle: Done=%b Busy=%b expected 0 0", bus.Done, bus.Busy);
    end
    cyc = 0;
  endtask

  task automatic test_sub_chain();
    int cyc;
    int exp;
    exp = model_op(1, 3, 5, 1'b0);
    issue(1, 3, 5, 1'b0);
    wait_done(cyc);
    checks++;
    if (bus.ALUout !== 8'hFE || cyc != 1) begin
      errors++;
      $display("FAIL sub_wrap: ALUout=%h cycles=%0d expected FE 1", bus.ALUout, cyc);
    end
    exp = model_op(0, 2, 9, 1'b1);
    issue(0, 2, 9, 1'b1);
    wait_done(cyc);
    checks++;
    if (bus.ALUout !== 8'h10 || exp != 8'h10) begin
      errors++;
      $display("FAIL useacc_add: ALUout=%h expected 10", bus.ALUout);
    end
  endtask

  task automatic test_mul();
    logic [7:0] old;
    int         exp;
    old = 8'(acc);
    exp = model_op(5, 15, 15, 1'b0);
    issue(5, 15, 15, 1'b0);
    for (int c = 1; c <= N; c++) begin
      checks++;
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.ALUout !== old) begin
        errors++;
        $display("FAIL mul_busy c%0d: Busy=%b Done=%b ALUout=%h expected 1 0 %h",
                 c, bus.Busy, bus.Done, bus.ALUout, old);
      end
      // Ignored request with different operands in the middle of the multiply.
      bus.Start = (c == 2);
      bus.A     = 4'h3;
      bus.B     = 4'h1;
      @(posedge Clock);
      #1;
      bus.Start = 1'b0;
    end
    checks++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b1 || bus.ALUout !== 8'hE1 || exp != 8'hE1) begin
      errors++;
      $display("FAIL mul_done: Done=%b Busy=%b ALUout=%h expected 1 1 E1",
               bus.Done, bus.Busy, bus.ALUout);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock);
      #1;
      checks++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.ALUout !== 8'hE1) begin
        errors++;
        $display("FAIL mul_after c%0d: Done=%b Busy=%b ALUout=%h expected 0 0 E1",
                 c, bus.Done, bus.Busy, bus.ALUout);
      end
    end
  endtask

  task automatic test_logic();
    int ops [5][3] = '{'{2, 0, 0}, '{3, 15, 15}, '{4, 10, 5}, '{6, 10, 5}, '{7, 10, 5}};
    int want [5]   = '{8'h00, 8'h01, 8'hA5, 8'h0F, 8'h00};
    int cyc;
    int exp;
    for (int i = 0; i < 5; i++) begin
      exp = model_op(ops[i][0], ops[i][1], ops[i][2], 1'b0);
      issue(ops[i][0], ops[i][1], ops[i][2], 1'b0);
      wait_done(cyc);
      checks++;
      if (bus.ALUout !== 8'(want[i]) || exp != want[i] || cyc != 1) begin
        errors++;
        $display("FAIL logic f%0d: ALUout=%h cycles=%0d expected %h 1",
                 ops[i][0], bus.ALUout, cyc, 8'(want[i]));
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    int cyc;
    int exp;
    issue(5, 7, 9, 1'b0);
    @(posedge Clock);
    #1;
    Reset_b = 1'b0;
    #1;
    acc = 0;
    checks++;
    if (bus.ALUout !== 8'h00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL midmul_reset: ALUout=%h Busy=%b Done=%b expected 00 0 0",
               bus.ALUout, bus.Busy, bus.Done);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge Clock);
      #1;
      checks++;
      if (bus.Done !== 1'b0) begin
        errors++;
        $display("FAIL midmul_nodone c%0d: Done=%b expected 0", c, bus.Done);
      end
    end
    @(negedge Clock);
    Reset_b = 1'b1;
    exp = model_op(5, 3, 4, 1'b0);
    issue(5, 3, 4, 1'b0);
    wait_done(cyc);
    checks++;
    if (bus.ALUout !== 8'h0C || exp != 8'h0C || cyc != N + 1) begin
      errors++;
      $display("FAIL midmul_fresh: ALUout=%h cycles=%0d expected 0C %0d",
               bus.ALUout, cyc, N + 1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int exp;
    exp = model_op(7, 0, 0, 1'b0);
    issue(7, 0, 0, 1'b0);
    wait_done(cyc);
    @(negedge Clock);
    @(negedge Clock);
    bus.Function = 3'b000;
    bus.A        = 4'h1;
    bus.UseAcc   = 1'b1;
    bus.Start    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock);
      #1;
      if (i % 2 == 0) exp = model_op(0, 1, 0, 1'b1);
      checks++;
      if (bus.Done !== 1'(i % 2 == 0) || bus.ALUout !== 8'(exp)) begin
        errors++;
        $display("FAIL held_start e%0d: Done=%b ALUout=%h expected %b %h",
                 i, bus.Done, bus.ALUout, 1'(i % 2 == 0), 8'(exp));
      end
    end
    bus.Start  = 1'b0;
    bus.UseAcc = 1'b0;
  endtask

  task automatic test_random();
    int  f, a, b, cyc, exp;
    bit  ua;
    for (int i = 0; i < 40; i++) begin
      f   = int'($urandom_range(7, 0));
      a   = int'($urandom_range(15, 0));
      b   = int'($urandom_range(15, 0));
      ua  = 1'($urandom_range(1, 0));
      exp = model_op(f, a, b, ua);
      issue(f, a, b, ua);
      wait_done(cyc);
      checks++;
      if (bus.ALUout !== 8'(exp) || cyc != ((f == 5) ? N + 1 : 1)) begin
        errors++;
        $display("FAIL random %0d f%0d a%h b%h ua%b: ALUout=%h cycles=%0d expected %h %0d",
                 i, f, a, b, ua, bus.ALUout, cyc, 8'(exp), (f == 5) ? N + 1 : 1);
      end
      @(posedge Clock);
      #1;
      checks++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
        errors++;
        $display("FAIL random_idle %0d: Done=%b Busy=%b expected 0 0", i, bus.Done, bus.Busy);
      end
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    acc          = 0;
    Reset_b      = 1'b0;
    bus.Start    = 1'b0;
    bus.Function = 3'b000;
    bus.UseAcc   = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    repeat (2) @(negedge Clock);
    Reset_b = 1'b1;
    test_reset();
    test_add();
    test_sub_chain();
    test_mul();
    test_logic();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu_acc.md
Name: seq_alu_acc

Overview:
Parametrised, registered successor to the four-function combinational ALU. It takes operands A and B, or the fed-back accumulator value in place of B, and runs one of eight functions selected by a 3-bit code. The result is held in a 2N-bit ALUout register. Multiply is a multi-cycle shift-add operation. All operations use a Start/Busy/Done handshake, and the block sits between switch/key inputs and the HEX/LED display logic.

Parameters:
N, 4, operand width; ALUout is 2N bits wide; N >= 2.

Ports:
Clock  input  1  system clock, rising edge.
Reset_b  input  1  asynchronous, active-low reset.
Start  input  1  request pulse/level; accepted only in IDLE.
Function  input  3  operation select, sampled at accept.
UseAcc  input  1  1: B operand = ALUout[N-1:0] (register value at accept); 0: B operand = B.
A  input  N  operand A.
B  input  N  operand B.
Busy  output  1  high in MUL and DONE states.
Done  output  1  one-cycle pulse; ALUout is valid and new in that cycle.
ALUout  output  2N  result register.

Behaviour:
- Reset (Reset_b=0, asynchronous, any state, including mid-multiply):
  - state=IDLE; ALUout=0, Busy=0, Done=0.
  - Internal multiplicand, multiplier, product and counter cleared.
- States: IDLE, MUL, DONE.
  - IDLE: Start=1 at an edge means accept.
    - Operands are A and Bop (B or ALUout[N-1:0]); Function is latched.
    - Function 101 goes to MUL; all other functions go to DONE.
  - MUL: runs exactly N cycles, then goes to DONE.
  - DONE: unconditionally returns to IDLE on the next edge.
- Start in MUL or DONE is ignored; it is not queued. A Start held high through DONE is accepted again in IDLE.
- Single-cycle functions: ALUout is written at the accept edge. Done=1 in the following cycle. Earliest next accept is 2 edges after the previous one.
- Input changes after accept have no effect on the running operation.
- Function codes (operands zero-extended to 2N; results modulo 2^2N):
  - 000: ALUout = A + Bop. The carry lands in bit N.
  - 001: ALUout = A - Bop, two's complement wrap, e.g. 3-5 gives all-ones minus 1.
  - 010: ALUout = {2N-1 zeros, |{A,Bop}}.
  - 011: ALUout = {2N-1 zeros, &{A,Bop}}.
  - 100: ALUout = {A, Bop}, A in the MSBs.
  - 101: ALUout = A * Bop, unsigned, shift-add.
  - 110: ALUout = A ^ Bop, zero-extended.
  - 111: ALUout = 0 (clear accumulator). Done still pulses.
- Multiply datapath:
  - At accept: mcand = zero-extended A (2N bits), mplier = Bop, prod = 0, cnt = N.
  - Each MUL cycle:
    - if mplier[0]: prod += mcand;
    - then mcand <<= 1, mplier >>= 1, cnt -= 1;
    - leave MUL when cnt reaches 0.
  - ALUout keeps its old value throughout MUL and is loaded with prod on the MUL-to-DONE edge.
  - Done goes high N+1 cycles after the accept edge.
  - Bop = 0 still takes N cycles (no early exit).
- UseAcc with Function 101 uses ALUout[N-1:0] as it was before the multiply begins.
- No overflow flag: the 2N-bit width holds every add, concat and multiply result exactly. Sub wraps.
- Done is never high in two consecutive cycles. Busy=0 exactly when in IDLE.

Test Plan:
- Reset_b=0 with ALUout nonzero -> ALUout=8'h00, Busy=0, Done=0 immediately, with no clock edge needed (N=4).
- Add: A=4'hF, B=4'h1, Function=000, Start for 1 cycle -> next cycle Done=1, ALUout=8'h10, Busy=1; IDLE after one more edge.
- Sub and UseAcc chain:
  - A=3, B=5, Function=001 -> ALUout=8'hFE.
  - Then A=4'h2, UseAcc=1, Function=000 -> ALUout=8'h10 (2+4'hE).
- Multiply: A=4'hF, B=4'hF, Function=101 -> Busy=1 for 5 cycles.
  - ALUout keeps its old value during MUL.
  - Done pulses on the 5th cycle after accept with ALUout=8'hE1.
  - Start pulses during MUL are ignored: no extra Done, result unchanged.
- Logic and concat:
  - A=0, B=0, Function=010 -> 8'h00.
  - A=F, B=F, Function=011 -> 8'h01.
  - A=4'hA, B=4'h5, Function=100 -> 8'hA5.
  - Function=110 with the same operands -> 8'h0F.
  - Function=111 -> 8'h00.
- Reset mid-multiply: assert Reset_b=0 on the 2nd MUL cycle -> IDLE, ALUout=0, no Done. A fresh 3*4 multiply after release -> ALUout=8'h0C.
